// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load/store path: FSM encoding and funct3 codes.
package rv32i_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: legality/alignment flags, byte mask, write-data
// replication and extraction/extension of the load lane.
module lsu_lane_align
   import rv32i_pkg::*;
(
   input  logic        store_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        legal_o,
   output logic        aligned_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Legality depends on direction: unsigned sizes exist only for loads.
   always_comb begin
      legal_o = 1'b0;
      case (funct3_i)
         F3_B, F3_H, F3_W: legal_o = 1'b1;
         F3_BU, F3_HU:     legal_o = ~store_i;
         default:          legal_o = 1'b0;
      endcase
   end

   // funct3[1:0] carries the access size for every legal code.
   always_comb begin
      aligned_o = 1'b0;
      be_o      = 4'b0000;
      wdata_o   = 32'h0;
      case (funct3_i[1:0])
         2'b00: begin
            aligned_o = 1'b1;
            be_o      = 4'b0001 << addr_lo_i;
            wdata_o   = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            aligned_o = ~addr_lo_i[0];
            be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdata_o   = {2{wdata_i[15:0]}};
         end
         2'b10: begin
            aligned_o = (addr_lo_i == 2'b00);
            be_o      = 4'b1111;
            wdata_o   = wdata_i;
         end
         default: begin
            aligned_o = 1'b0;
            be_o      = 4'b0000;
            wdata_o   = 32'h0;
         end
      endcase
   end

   // Pick the addressed lane from the read word, then sign- or zero-extend it.
   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      load_data_o = 32'h0;
      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    load_data_o = rdata_i;
         F3_BU:   load_data_o = {24'h0, byte_sel};
         F3_HU:   load_data_o = {16'h0, half_sel};
         default: load_data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request, performs a single-cycle RAM
// access (or rejects it), and returns an extended load result or an error.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the initiator holds valid and payload stable until then, and the
// responder's ready does not depend on valid.
module load_store_unit
   import rv32i_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [3:0]            byte_enable,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [1:0]            dbg_state
);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("load_store_unit: DATA_WIDTH must be 32");
   end

   lsu_state_e            state_q, state_d;
   logic                  store_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   // The lane block sees the live request in IDLE (for the accept-time check)
   // and the latched request otherwise (for the access itself).
   logic        sel_store;
   logic [2:0]  sel_funct3;
   logic [1:0]  sel_addr_lo;
   logic [31:0] sel_wdata;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic        al_legal;
   logic        al_aligned;
   logic [31:0] al_load;
   logic        in_idle;

   assign in_idle     = (state_q == IDLE);
   assign sel_store   = in_idle ? req_store      : store_q;
   assign sel_funct3  = in_idle ? req_funct3     : funct3_q;
   assign sel_addr_lo = in_idle ? req_addr[1:0]  : addr_q[1:0];
   assign sel_wdata   = in_idle ? req_wdata      : wdata_q;

   lsu_lane_align u_align (
      .store_i     (sel_store),
      .funct3_i    (sel_funct3),
      .addr_lo_i   (sel_addr_lo),
      .wdata_i     (sel_wdata),
      .rdata_i     (mem_rdata),
      .be_o        (al_be),
      .wdata_o     (al_wdata),
      .legal_o     (al_legal),
      .aligned_o   (al_aligned),
      .load_data_o (al_load)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: bad requests skip the access and go straight to the response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = (al_legal && al_aligned) ? ACCESS : RESP;
         ACCESS:  state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: RAM strobes and mask live only in ACCESS.
   always_comb begin
      req_ready   = (state_q == IDLE);
      rsp_valid   = (state_q == RESP);
      MemRead     = (state_q == ACCESS) && !store_q;
      MemWrite    = (state_q == ACCESS) && store_q;
      byte_enable = (state_q == ACCESS) ? al_be : 4'b0000;
      mem_wdata   = (state_q == ACCESS) ? al_wdata : 32'h0;
      mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      rsp_rdata   = rdata_q;
      rsp_err     = err_q;
      dbg_state   = state_q;
   end

   // Request latches and response registers; the response holds through RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         store_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  store_q  <= req_store;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  rdata_q  <= '0;
                  err_q    <= !(al_legal && al_aligned);
               end
            end
            ACCESS: begin
               rdata_q <= store_q ? 32'h0 : al_load;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
